// File: rtl/wb_burst_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pkg
//  Purpose  : Shared Wishbone B4 encodings and burst-master state codes.
//  Revision : 1.0  initial release
// ============================================================================
package wb_pkg;

    // Cycle type identifiers driven on wb_cti_o
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Burst type extension: only linear bursts are generated
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Burst-master sequencer states
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_BURST    = 2'd1;
    localparam logic [1:0] ST_DONE     = 2'd2;

endpackage
`default_nettype wire

// File: rtl/wb_burst_master_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : wb_ack_watchdog
//  Purpose  : Saturating counter of strobed cycles that saw no acknowledge.
//             o_timeout fires on the cycle the count reaches 2**TO_W-1.
//  Revision : 1.0  initial release
// ============================================================================
module wb_ack_watchdog #(
    parameter int TO_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam logic [TO_W-1:0] C_MAX = '1;

    logic [TO_W-1:0] r_cnt;

    // Count unacknowledged strobe cycles, holding at the maximum
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != C_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The cycle that would take the count to its maximum is the timeout cycle
    assign o_timeout = i_en && !i_clr && (r_cnt == (C_MAX - 1'b1));

endmodule
`default_nettype wire

// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : wb_burst_master
//  Purpose  : Wishbone B4 initiator turning queued burst commands into
//             incrementing-address bus cycles, streaming write data in and
//             read data out, with tagged per-command completion.
//  Revision : 1.0  initial release
// ============================================================================
module wb_burst_master
    import wb_pkg::*;
#(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int BL_W = 5,
    parameter int TW   = 8,
    parameter int TO_W = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [BL_W-1:0] cmd_len,
    input  logic [TW-1:0]   cmd_tag,
    input  logic            wdat_valid,
    output logic            wdat_ready,
    input  logic [DW-1:0]   wdat,
    input  logic [DW/8-1:0] wdat_be,
    output logic            rdat_valid,
    output logic [DW-1:0]   rdat,
    output logic            rdat_last,
    output logic            done_valid,
    output logic [TW-1:0]   done_tag,
    output logic            done_err,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic [DW-1:0]   wb_dat_i
);

    localparam int          SW     = DW / 8;
    localparam logic [AW-1:0] C_STEP = AW'(SW);

    logic [1:0]      r_state;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [BL_W-1:0] r_len;
    logic [BL_W-1:0] r_cnt;
    logic [TW-1:0]   r_tag;
    logic            r_err;
    logic            r_rdat_valid;
    logic            r_rdat_last;
    logic [DW-1:0]   r_rdat;

    logic w_burst;
    logic w_stb;
    logic w_last;
    logic w_ack;
    logic w_err;
    logic w_timeout;
    logic w_abort;

    // Writes insert master wait states by dropping stb while data is absent
    assign w_burst = (r_state == ST_BURST);
    assign w_stb   = w_burst && (!r_we || wdat_valid);
    assign w_last  = (r_cnt == r_len);
    // A simultaneous err overrides ack so the beat is never counted
    assign w_err   = w_stb && wb_err_i;
    assign w_ack   = w_stb && wb_ack_i && !wb_err_i;
    assign w_abort = w_err || w_timeout;

    wb_ack_watchdog #(
        .TO_W (TO_W)
    ) u_watchdog (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .i_clr     (!w_burst || w_ack),
        .i_en      (w_stb && !wb_ack_i),
        .o_timeout (w_timeout)
    );

    // Command sequencer: latch command, walk the beats, report completion
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_tag   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_state <= ST_BURST;
                        r_we    <= cmd_we;
                        r_addr  <= cmd_addr;
                        r_len   <= cmd_len;
                        r_cnt   <= '0;
                        r_tag   <= cmd_tag;
                        r_err   <= 1'b0;
                    end
                end
                ST_BURST: begin
                    if (w_abort) begin
                        r_state <= ST_DONE;
                        r_err   <= 1'b1;
                    end else if (w_ack) begin
                        r_addr <= r_addr + C_STEP;
                        r_cnt  <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read return path: one registered beat per acknowledged read strobe
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rdat_valid <= 1'b0;
            r_rdat_last  <= 1'b0;
            r_rdat       <= '0;
        end else begin
            r_rdat_valid <= w_ack && !r_we;
            r_rdat_last  <= w_ack && !r_we && w_last;
            if (w_ack && !r_we) begin
                r_rdat <= wb_dat_i;
            end
        end
    end

    assign cmd_ready  = (r_state == ST_IDLE);
    assign wdat_ready = w_ack && r_we;

    assign rdat_valid = r_rdat_valid;
    assign rdat       = r_rdat;
    assign rdat_last  = r_rdat_last;

    assign done_valid = (r_state == ST_DONE);
    assign done_tag   = r_tag;
    assign done_err   = r_err;

    assign wb_cyc_o   = w_burst;
    assign wb_stb_o   = w_stb;
    assign wb_we_o    = w_burst && r_we;
    assign wb_addr_o  = r_addr;
    assign wb_sel_o   = r_we ? wdat_be : {SW{1'b1}};
    assign wb_dat_o   = wdat;
    assign wb_cti_o   = w_burst ? (w_last ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
    assign wb_bte_o   = BTE_LINEAR;

endmodule
`default_nettype wire
